issue_queue_dual: RTL and testbench

- Dual-issue instruction queue between decode and the issue-to-EX register stage.
- Buffers up to DEPTH decoded instructions, accepting 0-2 per cycle in program order.
- Each cycle it presents the oldest one or two instructions as issue slot 1 and slot 2, each with a valid bit.
- Applies the dual-issue pairing rules and pops the issued count when the EX stage is not stalled.

---
 rtl/issue_queue_dual.sv | 124 ++++++++++++
 tb/tb_issue_queue_dual.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue_dual.sv
// Dual-issue in-order instruction queue: buffers decoded instructions and presents the oldest pair with pairing rules applied.
// Latency: one cycle decode-to-slot; the issue outputs are combinational from registered state.
// Backpressure: in_ready drops when fewer than two entries are free; stall_DCache/stall_div freeze the pop and hold the outputs stable.
module issue_queue_dual #(
  parameter int         DEPTH     = 16,
  parameter int         PAYLOAD_W = 256,
  parameter logic [9:0] ALU_TYPE  = 10'h001,
  parameter logic [9:0] SOLO_MASK = 10'h0F0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               in_valid,
  output logic                     in_ready,
  input  logic [PAYLOAD_W-1:0]     in_payload0,
  input  logic [PAYLOAD_W-1:0]     in_payload1,
  input  logic [9:0]               in_type0,
  input  logic [9:0]               in_type1,
  input  logic                     in_rf_we0,
  input  logic                     in_rf_we1,
  input  logic [4:0]               in_rd0,
  input  logic [4:0]               in_rd1,
  input  logic [4:0]               in_rs1_0,
  input  logic [4:0]               in_rs2_0,
  input  logic [4:0]               in_rs1_1,
  input  logic [4:0]               in_rs2_1,
  input  logic                     flush_BR,
  input  logic                     stall_DCache,
  input  logic                     stall_div,
  output logic                     out_valid1,
  output logic                     out_valid2,
  output logic [PAYLOAD_W-1:0]     out_payload1,
  output logic [PAYLOAD_W-1:0]     out_payload2,
  output logic [9:0]               out_type1,
  output logic [9:0]               out_type2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [9:0]           itype;
    logic                 rf_we;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  entry_t        w_ent0;
  entry_t        w_ent1;
  logic [PW-1:0] w_head1;
  logic [PW-1:0] w_wr1_idx;
  logic          w_enq;
  logic          w_wr0_en;
  logic          w_wr1_en;
  logic [CW-1:0] w_enq_n;
  logic [CW-1:0] w_pop_n;
  logic          w_pop;
  logic          w_hazard;
  logic          w_raw;

  assign w_ent0 = '{payload: in_payload0, itype: in_type0, rf_we: in_rf_we0,
                    rd: in_rd0, rs1: in_rs1_0, rs2: in_rs2_0};
  assign w_ent1 = '{payload: in_payload1, itype: in_type1, rf_we: in_rf_we1,
                    rd: in_rd1, rs1: in_rs1_1, rs2: in_rs2_1};

  // in_ready looks only at the registered count so it never depends on this cycle's pop
  assign in_ready  = (r_count <= CW'(DEPTH - 2));
  assign w_enq     = in_ready & ~flush_BR & ~rst;
  assign w_wr0_en  = w_enq & in_valid[0];
  assign w_wr1_en  = w_enq & in_valid[1];
  // lane1 lands behind lane0 when both are valid, otherwise directly at tail
  assign w_wr1_idx = in_valid[0] ? (r_tail + PW'(1)) : r_tail;
  assign w_enq_n   = CW'(w_wr0_en) + CW'(w_wr1_en);

  assign w_head1      = r_head + PW'(1);
  assign out_payload1 = r_mem[r_head].payload;
  assign out_payload2 = r_mem[w_head1].payload;
  assign out_type1    = r_mem[r_head].itype;
  assign out_type2    = r_mem[w_head1].itype;

  // slot 2 reading the register slot 1 writes cannot be bypassed within the pair
  assign w_raw = r_mem[r_head].rf_we && (r_mem[r_head].rd != 5'd0) &&
                 ((r_mem[r_head].rd == r_mem[w_head1].rs1) ||
                  (r_mem[r_head].rd == r_mem[w_head1].rs2));

  // only one non-ALU pipe exists, and solo-class instructions never pair
  assign w_hazard = ((out_type1 != ALU_TYPE) && (out_type2 != ALU_TYPE)) ||
                    (((out_type1 | out_type2) & SOLO_MASK) != 10'd0) ||
                    w_raw;

  assign out_valid1 = (r_count != '0);
  assign out_valid2 = (r_count >= CW'(2)) && !w_hazard;
  assign count      = r_count;

  assign w_pop   = ~flush_BR & ~stall_DCache & ~stall_div;
  assign w_pop_n = w_pop ? (CW'(out_valid1) + CW'(out_valid2)) : '0;

  // entry storage; contents outside head..tail are don't-care so no reset is needed
  always_ff @(posedge clk) begin
    if (w_wr0_en) r_mem[r_tail]    <= w_ent0;
    if (w_wr1_en) r_mem[w_wr1_idx] <= w_ent1;
  end

  // pointer and occupancy update; flush wipes everything including this cycle's enqueue and pop
  always_ff @(posedge clk) begin
    if (rst || flush_BR) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_pop_n);
      r_tail  <= r_tail + PW'(w_enq_n);
      r_count <= r_count + w_enq_n - w_pop_n;
    end
  end

endmodule

// File: tb/tb_issue_queue_dual.sv
module tb_issue_queue_dual;

  localparam int DEPTH = 16;
  localparam int PW    = 256;
  localparam logic [9:0] A   = 10'h001;
  localparam logic [9:0] MUL = 10'h004;
  localparam logic [9:0] DIV = 10'h008;
  localparam logic [9:0] CSR = 10'h010;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    in_valid;
  logic          in_ready;
  logic [PW-1:0] in_payload0, in_payload1;
  logic [9:0]    in_type0, in_type1;
  logic          in_rf_we0, in_rf_we1;
  logic [4:0]    in_rd0, in_rd1, in_rs1_0, in_rs2_0, in_rs1_1, in_rs2_1;
  logic          flush_BR, stall_DCache, stall_div;
  logic          out_valid1, out_valid2;
  logic [PW-1:0] out_payload1, out_payload2;
  logic [9:0]    out_type1, out_type2;
  logic [4:0]    count;

  issue_queue_dual #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_payload0(in_payload0), .in_payload1(in_payload1),
    .in_type0(in_type0), .in_type1(in_type1),
    .in_rf_we0(in_rf_we0), .in_rf_we1(in_rf_we1),
    .in_rd0(in_rd0), .in_rd1(in_rd1),
    .in_rs1_0(in_rs1_0), .in_rs2_0(in_rs2_0), .in_rs1_1(in_rs1_1), .in_rs2_1(in_rs2_1),
    .flush_BR(flush_BR), .stall_DCache(stall_DCache), .stall_div(stall_div),
    .out_valid1(out_valid1), .out_valid2(out_valid2),
    .out_payload1(out_payload1), .out_payload2(out_payload2),
    .out_type1(out_type1), .out_type2(out_type2), .count(count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int tag   = 1;

  typedef struct {
    logic [1:0] vld;
    logic [9:0] t0, t1;
    logic       we0; logic [4:0] rd0;
    logic       we1; logic [4:0] rd1;
    logic [4:0] rs1_1, rs2_1;
    logic       fl, sdc, sdiv, rs;
    int         e_cnt;
    logic       e_rdy, e_v1, e_v2;
    logic [9:0] e_t1;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // drive one cycle of inputs; payloads carry a unique tag in their low bits
  task automatic drive(input logic [1:0] vld, input logic [9:0] t0, input logic [9:0] t1,
                       input logic we0, input logic [4:0] rd0, input logic we1, input logic [4:0] rd1,
                       input logic [4:0] rs1_1, input logic [4:0] rs2_1,
                       input logic fl, input logic sdc, input logic sdiv, input logic rs);
    in_valid = vld; in_type0 = t0; in_type1 = t1;
    in_rf_we0 = we0; in_rd0 = rd0; in_rf_we1 = we1; in_rd1 = rd1;
    in_rs1_0 = 5'd0; in_rs2_0 = 5'd0; in_rs1_1 = rs1_1; in_rs2_1 = rs2_1;
    in_payload0 = PW'(tag); in_payload1 = PW'(tag + 1);
    tag += 2;
    flush_BR = fl; stall_DCache = sdc; stall_div = sdiv; rst = rs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic simple(input logic [1:0] vld, input logic fl, input logic sdc,
                        input logic sdiv, input logic rs);
    drive(vld, A, A, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, fl, sdc, sdiv, rs);
  endtask

  int base;
  int q[$];

  initial begin
    //            vld  t0   t1   we0  rd0   we1  rd1   rs1_1 rs2_1 fl   sdc  sdv  rst  cnt rdy  v1   v2   t1
    vecs[0]  = '{2'd0, A,   A,   1'b0,5'd0, 1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b1, 0, 1'b1,1'b0,1'b0, A};
    vecs[1]  = '{2'd3, A,   A,   1'b1,5'd3, 1'b0,5'd0, 5'd1, 5'd2, 1'b0,1'b0,1'b0,1'b0, 2, 1'b1,1'b1,1'b1, A};
    vecs[2]  = '{2'd0, A,   A,   1'b0,5'd0, 1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0, 0, 1'b1,1'b0,1'b0, A};
    vecs[3]  = '{2'd3, DIV, MUL, 1'b0,5'd0, 1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0, 2, 1'b1,1'b1,1'b0, DIV};
    vecs[4]  = '{2'd0, A,   A,   1'b0,5'd0, 1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0, 1, 1'b1,1'b1,1'b0, MUL};
    vecs[5]  = '{2'd0, A,   A,   1'b0,5'd0, 1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0, 0, 1'b1,1'b0,1'b0, A};
    vecs[6]  = '{2'd3, A,   A,   1'b1,5'd5, 1'b0,5'd0, 5'd0, 5'd5, 1'b0,1'b0,1'b0,1'b0, 2, 1'b1,1'b1,1'b0, A};
    vecs[7]  = '{2'd0, A,   A,   1'b0,5'd0, 1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0, 1, 1'b1,1'b1,1'b0, A};
    vecs[8]  = '{2'd0, A,   A,   1'b0,5'd0, 1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0, 0, 1'b1,1'b0,1'b0, A};
    vecs[9]  = '{2'd3, A,   A,   1'b1,5'd5, 1'b0,5'd0, 5'd5, 5'd0, 1'b0,1'b0,1'b0,1'b0, 2, 1'b1,1'b1,1'b0, A};
    vecs[10] = '{2'd0, A,   A,   1'b0,5'd0, 1'b0,5'd0, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0, 0, 1'b1,1'b0,1'b0, A};
    vecs[11] = '{2'd3, A,   A,   1'b1,5'd0, 1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0, 2, 1'b1,1'b1,1'b1, A};
    vecs[12] = '{2'd0, A,   A,   1'b0,5'd0, 1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0, 0, 1'b1,1'b0,1'b0, A};
    vecs[13] = '{2'd3, A,   CSR, 1'b0,5'd0, 1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0, 2, 1'b1,1'b1,1'b0, A};
    vecs[14] = '{2'd0, A,   A,   1'b0,5'd0, 1'b0,5'd0, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0, 0, 1'b1,1'b0,1'b0, A};
    vecs[15] = '{2'd3, CSR, A,   1'b0,5'd0, 1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0, 2, 1'b1,1'b1,1'b0, CSR};
    vecs[16] = '{2'd0, A,   A,   1'b0,5'd0, 1'b0,5'd0, 5'd0, 5'd0, 1'b1,1'b0,1'b0,1'b0, 0, 1'b1,1'b0,1'b0, A};
    vecs[17] = '{2'd2, DIV, MUL, 1'b0,5'd0, 1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0, 1, 1'b1,1'b1,1'b0, MUL};
    vecs[18] = '{2'd1, A,   DIV, 1'b0,5'd0, 1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0, 1, 1'b1,1'b1,1'b0, A};
    vecs[19] = '{2'd0, A,   A,   1'b0,5'd0, 1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0, 0, 1'b1,1'b0,1'b0, A};
    vecs[20] = '{2'd3, A,   A,   1'b1,5'd7, 1'b1,5'd7, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0, 2, 1'b1,1'b1,1'b1, A};
    vecs[21] = '{2'd0, A,   A,   1'b0,5'd0, 1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0, 0, 1'b1,1'b0,1'b0, A};
    vecs[22] = '{2'd3, A,   MUL, 1'b0,5'd0, 1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0, 2, 1'b1,1'b1,1'b1, A};
    vecs[23] = '{2'd0, A,   A,   1'b0,5'd0, 1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,1'b0,1'b0, 0, 1'b1,1'b0,1'b0, A};

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].vld, vecs[i].t0, vecs[i].t1, vecs[i].we0, vecs[i].rd0, vecs[i].we1,
            vecs[i].rd1, vecs[i].rs1_1, vecs[i].rs2_1, vecs[i].fl, vecs[i].sdc, vecs[i].sdiv, vecs[i].rs);
      tick();
      chk($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d out_valid1", i), 32'(out_valid1), 32'(vecs[i].e_v1));
      chk($sformatf("v%0d out_valid2", i), 32'(out_valid2), 32'(vecs[i].e_v2));
      if (vecs[i].e_v1) chk($sformatf("v%0d out_type1", i), 32'(out_type1), 32'(vecs[i].e_t1));
    end

    // fill to 15 under stall, full queue ignores input, then pop two
    base = tag;
    for (int i = 0; i < 7; i++) begin simple(2'd3, 1'b0, 1'b0, 1'b1, 1'b0); tick(); end
    chk("fill14 count", 32'(count), 32'd14);
    chk("fill14 in_ready", 32'(in_ready), 32'd1);
    simple(2'd1, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    chk("fill15 count", 32'(count), 32'd15);
    chk("fill15 in_ready", 32'(in_ready), 32'd0);
    simple(2'd3, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    chk("full ignore count", 32'(count), 32'd15);
    chk("full head payload", 32'(out_payload1[15:0]), 32'(base));
    simple(2'd0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("pop2 count", 32'(count), 32'd13);
    chk("pop2 in_ready", 32'(in_ready), 32'd1);
    chk("pop2 head payload", 32'(out_payload1[15:0]), 32'(base + 2));
    simple(2'd0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    chk("flush after fill", 32'(count), 32'd0);

    // stall_div held five cycles with four entries: nothing moves
    base = tag;
    simple(2'd3, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    simple(2'd3, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    for (int i = 0; i < 5; i++) begin
      simple(2'd0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
      chk($sformatf("stall%0d count", i), 32'(count), 32'd4);
      chk($sformatf("stall%0d payload1", i), 32'(out_payload1[15:0]), 32'(base));
      chk($sformatf("stall%0d payload2", i), 32'(out_payload2[15:0]), 32'(base + 1));
      chk($sformatf("stall%0d valid2", i), 32'(out_valid2), 32'd1);
    end
    simple(2'd0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    chk("unstall count", 32'(count), 32'd2);
    chk("unstall payload1", 32'(out_payload1[15:0]), 32'(base + 2));

    // grow to 6, then flush beats enqueue and stall together
    simple(2'd3, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    simple(2'd3, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    chk("preflush count", 32'(count), 32'd6);
    simple(2'd3, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    chk("flush count", 32'(count), 32'd0);
    chk("flush valid1", 32'(out_valid1), 32'd0);

    // reset mid-operation with nine entries
    for (int i = 0; i < 4; i++) begin simple(2'd3, 1'b0, 1'b0, 1'b1, 1'b0); tick(); end
    simple(2'd1, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    chk("prereset count", 32'(count), 32'd9);
    simple(2'd0, 1'b0, 1'b0, 1'b1, 1'b1); tick();
    chk("reset count", 32'(count), 32'd0);
    chk("reset valid1", 32'(out_valid1), 32'd0);

    // pointer wrap across many laps against an in-order scoreboard
    q.delete();
    for (int c = 0; c < 120; c++) begin
      logic [1:0] v;
      logic       st;
      int         cur, pn, t0v;
      case (c % 4)
        0: v = 2'd3;
        1: v = 2'd1;
        2: v = 2'd2;
        default: v = 2'd3;
      endcase
      st  = ((c % 7) >= 5) || (c >= 40 && c < 52);
      cur = q.size();
      pn  = st ? 0 : ((cur >= 2) ? 2 : cur);
      t0v = tag;
      simple(v, 1'b0, 1'b0, st, 1'b0);
      tick();
      for (int k = 0; k < pn; k++) void'(q.pop_front());
      if (cur <= DEPTH - 2) begin
        if (v[0]) q.push_back(t0v);
        if (v[1]) q.push_back(t0v + 1);
      end
      chk($sformatf("wrap%0d count", c), 32'(count), 32'(q.size()));
      if (q.size() >= 1) chk($sformatf("wrap%0d payload1", c), 32'(out_payload1[15:0]), 32'(q[0]));
      if (q.size() >= 2) chk($sformatf("wrap%0d payload2", c), 32'(out_payload2[15:0]), 32'(q[1]));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
